// File: rtl/lfsr_share_arb_pkg.sv
// Shared types, default constants and the LFSR step function for the shared-LFSR arbiter.
package lfsr_arb_pkg;

   localparam int unsigned DEF_WIDTH  = 4;
   localparam int unsigned LFSR_MAX_W = 16;
   localparam logic [DEF_WIDTH-1:0] DEF_TAPS = 4'b1100;
   localparam logic [DEF_WIDTH-1:0] DEF_SEED = 4'b0001;

   typedef enum logic [1:0] {
      S_SEED  = 2'd0,
      S_IDLE  = 2'd1,
      S_GRANT = 2'd2
   } state_t;

   // Fibonacci step on the low w bits: shift left, feed back the parity of the tapped bits.
   function automatic logic [LFSR_MAX_W-1:0] lfsr_next(input logic [LFSR_MAX_W-1:0] v,
                                                       input logic [LFSR_MAX_W-1:0] taps,
                                                       input int unsigned w);
      logic [LFSR_MAX_W-1:0] mask;
      mask = (LFSR_MAX_W'(1) << w) - LFSR_MAX_W'(1);
      return ((v << 1) | LFSR_MAX_W'(^(v & taps & mask))) & mask;
   endfunction

endpackage

// File: rtl/lfsr_share_arb_if.sv
// Requester-side bus of the shared-LFSR arbiter: requests and seeding in, grant and random word out.
interface lfsr_share_arb_if #(
   parameter int unsigned NUM_REQ = 4,
   parameter int unsigned WIDTH   = 4
);
   localparam int unsigned ID_W = $clog2(NUM_REQ);

   logic [NUM_REQ-1:0] req_i;
   logic               seed_load_i;
   logic [WIDTH-1:0]   seed_i;
   logic [NUM_REQ-1:0] gnt_o;
   logic [ID_W-1:0]    gnt_id_o;
   logic               rand_valid_o;
   logic [WIDTH-1:0]   rand_o;
   logic               wrap_o;

   modport master (
      output req_i, seed_load_i, seed_i,
      input  gnt_o, gnt_id_o, rand_valid_o, rand_o, wrap_o
   );

   modport slave (
      input  req_i, seed_load_i, seed_i,
      output gnt_o, gnt_id_o, rand_valid_o, rand_o, wrap_o
   );
endinterface

// File: rtl/lfsr_share_arb_lfsr_core.sv
// Fibonacci LFSR register with synchronous load (priority) and step enable.
module lfsr_core
   import lfsr_arb_pkg::*;
#(
   parameter int unsigned      WIDTH = DEF_WIDTH,
   parameter logic [WIDTH-1:0] TAPS  = WIDTH'(DEF_TAPS),
   parameter logic [WIDTH-1:0] SEED  = WIDTH'(DEF_SEED)
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             en_i,
   input  logic             load_i,
   input  logic [WIDTH-1:0] load_val_i,
   output logic [WIDTH-1:0] lfsr_o
);

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         lfsr_o <= SEED;
      end else if (load_i) begin
         lfsr_o <= load_val_i;
      end else if (en_i) begin
         lfsr_o <= WIDTH'(lfsr_next(LFSR_MAX_W'(lfsr_o), LFSR_MAX_W'(TAPS), WIDTH));
      end
   end

endmodule

// File: rtl/lfsr_share_arb.sv
// Round-robin sharing of one LFSR among NUM_REQ requesters; each grant hands out the
// current LFSR word and steps the generator. Handles seeding and zero-lockup recovery.
module lfsr_share_arb
   import lfsr_arb_pkg::*;
#(
   parameter int unsigned      NUM_REQ = 4,
   parameter int unsigned      WIDTH   = DEF_WIDTH,
   parameter logic [WIDTH-1:0] TAPS    = WIDTH'(DEF_TAPS),
   parameter logic [WIDTH-1:0] SEED    = WIDTH'(DEF_SEED)
) (
   input  logic            clk,
   input  logic            reset,
   lfsr_share_arb_if.slave bus
);

   localparam int unsigned ID_W = $clog2(NUM_REQ);

   state_t             state_q, state_d;
   logic [ID_W-1:0]    rr_ptr_q, rr_ptr_d;
   logic [ID_W-1:0]    gnt_id_q, gnt_id_d;
   logic [ID_W-1:0]    gnt_idx;
   logic [WIDTH-1:0]   loaded_seed_q, loaded_seed_d;
   logic [WIDTH-1:0]   rand_q, rand_d;
   logic [WIDTH-1:0]   lfsr, lfsr_nxt, seed_eff, lfsr_load_val;
   logic [NUM_REQ-1:0] gnt_q, gnt_d;
   logic               rand_valid_q, rand_valid_d;
   logic               wrap_q, wrap_d;
   logic               lfsr_en, lfsr_load, found, lockup;

   function automatic logic [ID_W-1:0] wrap_add(input logic [ID_W-1:0] base,
                                                input int unsigned off);
      int unsigned k;
      k = 32'(base) + off;
      if (k >= NUM_REQ) k = k - NUM_REQ;
      return ID_W'(k);
   endfunction

   lfsr_core #(
      .WIDTH (WIDTH),
      .TAPS  (TAPS),
      .SEED  (SEED)
   ) u_lfsr (
      .clk        (clk),
      .reset      (reset),
      .en_i       (lfsr_en),
      .load_i     (lfsr_load),
      .load_val_i (lfsr_load_val),
      .lfsr_o     (lfsr)
   );

   assign lfsr_nxt = WIDTH'(lfsr_next(LFSR_MAX_W'(lfsr), LFSR_MAX_W'(TAPS), WIDTH));
   assign seed_eff = (bus.seed_i == '0) ? SEED : bus.seed_i;
   assign lockup   = (lfsr == '0) && (state_q != S_SEED);

   // Circular search for the first request at or after rr_ptr.
   always_comb begin
      found   = 1'b0;
      gnt_idx = '0;
      for (int unsigned i = 0; i < NUM_REQ; i++) begin
         if (!found && bus.req_i[wrap_add(rr_ptr_q, i)]) begin
            found   = 1'b1;
            gnt_idx = wrap_add(rr_ptr_q, i);
         end
      end
   end

   always_comb begin
      state_d       = state_q;
      rr_ptr_d      = rr_ptr_q;
      loaded_seed_d = loaded_seed_q;
      gnt_d         = '0;
      gnt_id_d      = gnt_id_q;
      rand_valid_d  = 1'b0;
      rand_d        = rand_q;
      wrap_d        = 1'b0;
      lfsr_en       = 1'b0;
      lfsr_load     = 1'b0;
      lfsr_load_val = loaded_seed_q;

      if (bus.seed_load_i) begin
         lfsr_load     = 1'b1;
         lfsr_load_val = seed_eff;
         loaded_seed_d = seed_eff;
         state_d       = S_SEED;
      end else if (lockup) begin
         state_d = S_SEED;
      end else begin
         case (state_q)
            S_SEED: begin
               lfsr_load = 1'b1;
               state_d   = S_IDLE;
            end
            S_IDLE: begin
               if (|bus.req_i) state_d = S_GRANT;
            end
            S_GRANT: begin
               if (found) begin
                  gnt_d        = NUM_REQ'(1) << gnt_idx;
                  gnt_id_d     = gnt_idx;
                  rand_valid_d = 1'b1;
                  rand_d       = lfsr;
                  wrap_d       = (lfsr_nxt == loaded_seed_q);
                  lfsr_en      = 1'b1;
                  rr_ptr_d     = wrap_add(gnt_idx, 1);
               end else begin
                  state_d = S_IDLE;
               end
            end
            default: state_d = S_SEED;
         endcase
      end
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state_q       <= S_SEED;
         rr_ptr_q      <= '0;
         loaded_seed_q <= SEED;
         gnt_q         <= '0;
         gnt_id_q      <= '0;
         rand_valid_q  <= 1'b0;
         rand_q        <= '0;
         wrap_q        <= 1'b0;
      end else begin
         state_q       <= state_d;
         rr_ptr_q      <= rr_ptr_d;
         loaded_seed_q <= loaded_seed_d;
         gnt_q         <= gnt_d;
         gnt_id_q      <= gnt_id_d;
         rand_valid_q  <= rand_valid_d;
         rand_q        <= rand_d;
         wrap_q        <= wrap_d;
      end
   end

   assign bus.gnt_o        = gnt_q;
   assign bus.gnt_id_o     = gnt_id_q;
   assign bus.rand_valid_o = rand_valid_q;
   assign bus.rand_o       = rand_q;
   assign bus.wrap_o       = wrap_q;

endmodule

// File: tb/tb_lfsr_share_arb.sv
// Self-checking bench for lfsr_share_arb: directed scenarios plus random traffic against
// a transaction-level model built on the precomputed LFSR orbit.
module tb_lfsr_share_arb;

   localparam int unsigned NR = 4;
   localparam int unsigned W  = 4;

   logic clk;
   logic reset;

   lfsr_share_arb_if #(.NUM_REQ(NR), .WIDTH(W)) bus ();

   lfsr_share_arb #(
      .NUM_REQ (NR),
      .WIDTH   (W),
      .TAPS    (4'b1100),
      .SEED    (4'b0001)
   ) dut (
      .clk   (clk),
      .reset (reset),
      .bus   (bus.slave)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   int total = 0;
   int bad   = 0;

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      total++;
      if (got !== exp) begin
         bad++;
         $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
      end
   endtask

   // Model: LFSR as a position on its 15-long orbit, phase 0=seeding 1=idle 2=granting.
   int orbit [15];
   int gold  [15] = '{1, 2, 4, 9, 3, 6, 13, 10, 5, 11, 7, 15, 14, 12, 8};
   int m_phase, m_pos, m_loaded, m_rr;
   int e_gnt, e_id, e_valid, e_rand, e_wrap;

   function automatic int idx_of(input int v);
      for (int i = 0; i < 15; i++) if (orbit[i] == v) return i;
      return 0;
   endfunction

   task automatic model_reset();
      m_phase  = 0;
      m_loaded = 1;
      m_pos    = idx_of(1);
      m_rr     = 0;
      e_gnt = 0; e_id = 0; e_valid = 0; e_rand = 0; e_wrap = 0;
   endtask

   task automatic model_step(input int req, input int sl, input int seed);
      bit hit;
      e_gnt = 0; e_valid = 0; e_wrap = 0;
      if (sl != 0) begin
         m_loaded = (seed == 0) ? 1 : seed;
         m_pos    = idx_of(m_loaded);
         m_phase  = 0;
      end else if (m_phase == 0) begin
         m_pos   = idx_of(m_loaded);
         m_phase = 1;
      end else if (m_phase == 1) begin
         if (req != 0) m_phase = 2;
      end else if (req == 0) begin
         m_phase = 1;
      end else begin
         hit = 0;
         for (int i = 0; i < NR; i++) begin
            int k;
            k = (m_rr + i) % NR;
            if (!hit && ((req >> k) & 1) == 1) begin
               hit  = 1;
               e_id = k;
            end
         end
         e_gnt   = 1 << e_id;
         e_valid = 1;
         e_rand  = orbit[m_pos];
         m_pos   = (m_pos + 1) % 15;
         e_wrap  = (orbit[m_pos] == m_loaded) ? 1 : 0;
         m_rr    = (e_id + 1) % NR;
      end
   endtask

   task automatic step_check(input string tag);
      @(posedge clk);
      model_step(int'(bus.req_i), int'(bus.seed_load_i), int'(bus.seed_i));
      #1;
      check($sformatf("%s.gnt", tag),   32'(bus.gnt_o),        32'(e_gnt));
      check($sformatf("%s.id", tag),    32'(bus.gnt_id_o),     32'(e_id));
      check($sformatf("%s.valid", tag), 32'(bus.rand_valid_o), 32'(e_valid));
      check($sformatf("%s.rand", tag),  32'(bus.rand_o),       32'(e_rand));
      check($sformatf("%s.wrap", tag),  32'(bus.wrap_o),       32'(e_wrap));
   endtask

   task automatic check_cleared(input string tag);
      check($sformatf("%s.gnt", tag),   32'(bus.gnt_o),        32'(0));
      check($sformatf("%s.id", tag),    32'(bus.gnt_id_o),     32'(0));
      check($sformatf("%s.valid", tag), 32'(bus.rand_valid_o), 32'(0));
      check($sformatf("%s.rand", tag),  32'(bus.rand_o),       32'(0));
      check($sformatf("%s.wrap", tag),  32'(bus.wrap_o),       32'(0));
   endtask

   // Step until the model expects a grant; returns 0 if the bound runs out.
   task automatic step_to_grant(input string tag, input int budget, output bit ok);
      ok = 0;
      for (int n = 0; n < budget && !ok; n++) begin
         step_check(tag);
         if (e_valid != 0) ok = 1;
      end
      if (!ok) check($sformatf("%s.reach", tag), 32'(0), 32'(1));
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not finish, total=%0d bad=%0d", total, bad);
      $fatal(1);
   end

   initial begin
      int v;
      bit ok;
      reset           = 1'b0;
      bus.req_i       = '0;
      bus.seed_load_i = 1'b0;
      bus.seed_i      = '0;
      v = 1;
      for (int i = 0; i < 15; i++) begin
         orbit[i] = v;
         v = ((v << 1) & 15) | (((v >> 3) ^ (v >> 2)) & 1);
      end
      model_reset();

      #12;
      check_cleared("reset");

      // Single requester from reset: full period and wrap on the 15th grant.
      bus.req_i = 4'b0001;
      @(negedge clk) reset = 1'b1;
      step_check("t1.pre");
      step_check("t1.pre");
      for (int n = 0; n < 15; n++) begin
         step_check("t1");
         check("t1.seq",   32'(bus.rand_o), 32'(gold[n]));
         check("t1.wrapn", 32'(bus.wrap_o), 32'(n == 14));
      end

      // All requesting: one grant per cycle, rotating.
      bus.req_i = 4'b1111;
      for (int n = 0; n < 8; n++) begin
         step_check("t2");
         check("t2.nogap", 32'(bus.rand_valid_o), 32'(1));
      end

      // rr_ptr=2 with requesters 0 and 3: 3,0,3.
      bus.req_i = 4'b0010;
      ok = 0;
      for (int n = 0; n < 8 && !ok; n++) begin
         step_check("t3.pre");
         if (e_valid != 0 && e_id == 1) ok = 1;
      end
      if (!ok) check("t3.reach", 32'(0), 32'(1));
      bus.req_i = 4'b1001;
      step_check("t3"); check("t3.id0", 32'(bus.gnt_id_o), 32'(3));
      step_check("t3"); check("t3.id1", 32'(bus.gnt_id_o), 32'(0));
      step_check("t3"); check("t3.id2", 32'(bus.gnt_id_o), 32'(3));

      // Seed load during grant aborts the grant; sequence restarts at 8.
      bus.req_i       = 4'b0001;
      bus.seed_load_i = 1'b1;
      bus.seed_i      = 4'b1000;
      step_check("t4.load");
      check("t4.abort", 32'(bus.rand_valid_o), 32'(0));
      bus.seed_load_i = 1'b0;
      step_to_grant("t4", 6, ok);
      check("t4.first",  32'(bus.rand_o), 32'(8));
      step_check("t4");
      check("t4.second", 32'(bus.rand_o), 32'(1));

      // Zero seed falls back to the default seed.
      bus.seed_load_i = 1'b1;
      bus.seed_i      = 4'b0000;
      step_check("t5.load");
      bus.seed_load_i = 1'b0;
      step_to_grant("t5", 6, ok);
      check("t5.first", 32'(bus.rand_o), 32'(1));
      step_check("t5");
      check("t5.second", 32'(bus.rand_o), 32'(2));

      // Asynchronous reset between clock edges.
      step_check("t6.run");
      step_check("t6.run");
      #2 reset = 1'b0;
      #1;
      check_cleared("t6.async");
      model_reset();
      @(negedge clk) reset = 1'b1;
      step_to_grant("t6", 6, ok);
      check("t6.first", 32'(bus.rand_o), 32'(1));

      // Random traffic with occasional seed loads.
      for (int n = 0; n < 400; n++) begin
         bus.req_i = 4'($urandom_range(0, 15));
         if ($urandom_range(0, 19) == 0) begin
            bus.seed_load_i = 1'b1;
            bus.seed_i      = 4'($urandom_range(0, 15));
         end
         step_check("rnd");
         bus.seed_load_i = 1'b0;
      end

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
